// File: rtl/bcd_7seg_scan_driver.sv
// Purpose : time-multiplexed N-digit BCD to 7-segment driver with leading-zero
//           blanking, dash glyph for non-BCD codes and selectable polarity.
// Latency : seg/dp/an/frame_tick are registered, 1 cycle after index/shadow.
// Backpressure: none; load is always accepted, cs=0 darkens and parks the scan.
//
// Ports:
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   cs            1 = scan running, 0 = display dark with scan parked at digit 0
//   load          captures bcd/dp_in into the shadow registers on this edge
//   bcd, dp_in    packed digits ([3:0] = rightmost digit 0) and decimal points
//   seg, dp, an   segment lines {a..g}, decimal point and one-hot digit enable
//   frame_tick    1-cycle pulse when the scan returns to digit 0 after a wrap

module bcd_7seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1000,
  parameter int LZ_SUPPRESS    = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = $clog2(PRESCALE);

  // Internal state is kept active-high; polarity is a constant XOR on the
  // flop outputs, so reset and blank states follow the selected polarity.
  localparam logic [6:0]            SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_MASK  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_MASK  = (AN_ACTIVE_LOW != 0) ?
                                               {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [4*NUM_DIGITS-1:0] bcd_sh_q, bcd_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [PS_W-1:0]         ps_q, ps_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wrap_pend_q, wrap_pend_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    ps_last;
  logic                    idx_last;
  logic [3:0]              sel_dig;
  logic                    sel_dp;
  logic                    sel_blank;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   an_sel;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000001;  // dash for codes 10..15
    endcase
    return s;
  endfunction

  // Shadow capture and scan counters.
  always_comb begin
    bcd_sh_d    = load ? bcd   : bcd_sh_q;
    dp_sh_d     = load ? dp_in : dp_sh_q;

    ps_last     = (ps_q  == PS_W'(PRESCALE - 1));
    idx_last    = (idx_q == IDX_W'(NUM_DIGITS - 1));

    ps_d        = '0;
    idx_d       = '0;
    if (cs) begin
      if (ps_last) begin
        ps_d  = '0;
        idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
      end else begin
        ps_d  = ps_q + PS_W'(1);
        idx_d = idx_q;
      end
    end

    // The wrap is seen one cycle before the digit-0 outputs are registered,
    // so it is held for one cycle to line frame_tick up with an.
    wrap_pend_d  = cs & ps_last & idx_last;
    frame_tick_d = cs & wrap_pend_q;
  end

  // Digit select and leading-zero detection. The walk runs from the most
  // significant digit down; all_zero stays set only while every digit seen so
  // far is 0, so any non-zero code (including non-BCD) ends the blanking.
  always_comb begin
    sel_dig   = 4'd0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    all_zero  = 1'b1;
    an_sel    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero & (bcd_sh_q[4*k +: 4] == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        an_sel[k] = 1'b1;
        sel_dig   = bcd_sh_q[4*k +: 4];
        sel_dp    = dp_sh_q[k];
        if ((LZ_SUPPRESS != 0) && (k != 0) && all_zero) begin
          sel_blank = 1'b1;
        end
      end
    end
  end

  // Output stage: cs=0 forces all lines inactive.
  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = '0;
    if (cs) begin
      seg_d = sel_blank ? 7'b0000000 : seg_decode(sel_dig);
      dp_d  = sel_dp;
      an_d  = an_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_sh_q     <= '0;
      dp_sh_q      <= '0;
      ps_q         <= '0;
      idx_q        <= '0;
      wrap_pend_q  <= 1'b0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      bcd_sh_q     <= bcd_sh_d;
      dp_sh_q      <= dp_sh_d;
      ps_q         <= ps_d;
      idx_q        <= idx_d;
      wrap_pend_q  <= wrap_pend_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q ^ SEG_MASK;
  assign dp         = dp_q ^ DP_MASK;
  assign an         = an_q ^ AN_MASK;
  assign frame_tick = frame_tick_q;

endmodule
